// File: rtl/cube_rule_pkg.sv
// Shared defaults and the rule record for the cube rule engine.
// Rule fields are stored at MAX_WIDTH so one record type serves any WIDTH up to it.
package cube_rule_pkg;

  localparam int DEF_WIDTH = 5;
  localparam int DEF_RULES = 8;
  localparam int DEF_CNT_W = 16;
  localparam int MAX_WIDTH = 32;

  typedef struct packed {
    logic                 en;
    logic [MAX_WIDTH-1:0] mask;
    logic [MAX_WIDTH-1:0] val;
  } rule_t;

endpackage

// File: rtl/cube_match.sv
// One cube rule: matches when enabled and every cared-for bit equals its literal.
module cube_match #(
  parameter int WIDTH = 5
) (
  input  logic             i_en,
  input  logic [WIDTH-1:0] i_mask,
  input  logic [WIDTH-1:0] i_val,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_match
);

  assign o_match = i_en && (((i_data ^ i_val) & i_mask) == '0);

endmodule

// File: rtl/cube_rule_engine.sv
// Two-stage cube-rule matcher with a programmable rule table, global-stall
// handshake, fixed-priority first-match encode and saturating per-rule hit counters.
module cube_rule_engine
  import cube_rule_pkg::*;
#(
  parameter  int WIDTH = DEF_WIDTH,
  parameter  int RULES = DEF_RULES,
  parameter  int CNT_W = DEF_CNT_W,
  localparam int IDX_W = $clog2(RULES)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cfg_we,
  input  logic [IDX_W-1:0] cfg_idx,
  input  logic             cfg_en,
  input  logic [WIDTH-1:0] cfg_mask,
  input  logic [WIDTH-1:0] cfg_val,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [RULES-1:0] out_match,
  output logic             out_any,
  output logic [IDX_W-1:0] out_first,
  input  logic [IDX_W-1:0] cnt_idx,
  output logic [CNT_W-1:0] cnt_value,
  input  logic             cnt_clr
);

  rule_t                r_rules [RULES];
  logic                 r_s1Valid;
  logic [WIDTH-1:0]     r_s1Data;
  logic                 r_s2Valid;
  logic [RULES-1:0]     r_s2Match;
  logic [CNT_W-1:0]     r_cnt [RULES];

  logic                 w_advance;
  logic                 w_consume;
  logic [RULES-1:0]     w_match;
  logic [MAX_WIDTH-1:0] w_dataExt;
  logic [IDX_W-1:0]     w_first;

  // Reset flushes the pipeline, so the input side reads ready throughout it.
  assign w_advance = !rst_n || !r_s2Valid || out_ready;
  assign w_consume = r_s2Valid && out_ready;
  assign w_dataExt = MAX_WIDTH'(r_s1Data);

  for (genvar g = 0; g < RULES; g++) begin : g_rule
    cube_match #(.WIDTH(MAX_WIDTH)) u_match (
      .i_en    (r_rules[g].en),
      .i_mask  (r_rules[g].mask),
      .i_val   (r_rules[g].val),
      .i_data  (w_dataExt),
      .o_match (w_match[g])
    );
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int r = 0; r < RULES; r++) r_rules[r] <= '0;
    end else if (cfg_we && (int'(cfg_idx) < RULES)) begin
      r_rules[cfg_idx] <= '{en: cfg_en, mask: MAX_WIDTH'(cfg_mask), val: MAX_WIDTH'(cfg_val)};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_s1Valid <= 1'b0;
      r_s1Data  <= '0;
      r_s2Valid <= 1'b0;
      r_s2Match <= '0;
    end else if (w_advance) begin
      r_s1Valid <= in_valid;
      r_s1Data  <= in_data;
      r_s2Valid <= r_s1Valid;
      r_s2Match <= r_s1Valid ? w_match : '0;
    end
  end

  // Clear outranks a same-cycle increment.
  always_ff @(posedge clk) begin
    if (!rst_n || cnt_clr) begin
      for (int r = 0; r < RULES; r++) r_cnt[r] <= '0;
    end else if (w_consume) begin
      for (int r = 0; r < RULES; r++) begin
        if (r_s2Match[r] && (r_cnt[r] != '1)) r_cnt[r] <= r_cnt[r] + 1'b1;
      end
    end
  end

  always_comb begin
    w_first = '0;
    for (int r = RULES - 1; r >= 0; r--) begin
      if (r_s2Match[r]) w_first = IDX_W'(r);
    end
  end

  always_comb begin
    cnt_value = '0;
    if (int'(cnt_idx) < RULES) cnt_value = r_cnt[cnt_idx];
  end

  assign in_ready  = w_advance;
  assign out_valid = r_s2Valid;
  assign out_match = r_s2Match;
  assign out_any   = |r_s2Match;
  assign out_first = w_first;

endmodule

// File: tb/tb_cube_rule_engine.sv
// Self-checking bench for cube_rule_engine: directed scenarios plus randomized
// traffic scored against a transaction-level model of the rule semantics.
module tb_cube_rule_engine;

  localparam int WIDTH   = 5;
  localparam int RULES   = 8;
  localparam int CNT_W   = 4;
  localparam int IDX_W   = 3;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             cfg_we;
  logic [IDX_W-1:0] cfg_idx;
  logic             cfg_en;
  logic [WIDTH-1:0] cfg_mask;
  logic [WIDTH-1:0] cfg_val;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [RULES-1:0] out_match;
  logic             out_any;
  logic [IDX_W-1:0] out_first;
  logic [IDX_W-1:0] cnt_idx;
  logic [CNT_W-1:0] cnt_value;
  logic             cnt_clr;

  always #5 clk = ~clk;

  cube_rule_engine #(.WIDTH(WIDTH), .RULES(RULES), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cfg_we    (cfg_we),
    .cfg_idx   (cfg_idx),
    .cfg_en    (cfg_en),
    .cfg_mask  (cfg_mask),
    .cfg_val   (cfg_val),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_match (out_match),
    .out_any   (out_any),
    .out_first (out_first),
    .cnt_idx   (cnt_idx),
    .cnt_value (cnt_value),
    .cnt_clr   (cnt_clr)
  );

  typedef struct {
    logic [WIDTH-1:0] data;
    bit               resolved;
    logic [RULES-1:0] match;
  } beat_t;

  beat_t            expQ[$];
  bit               mEn   [RULES];
  logic [WIDTH-1:0] mMask [RULES];
  logic [WIDTH-1:0] mVal  [RULES];
  int               mCnt  [RULES];
  int               checkCount = 0;
  int               passCount  = 0;
  int               failCount  = 0;

  logic [WIDTH-1:0] tblMask [RULES] = '{5'b10011, 5'b01101, 5'b11001, 5'b10001,
                                        5'b01010, 5'b00100, 5'b00010, 5'b10001};
  logic [WIDTH-1:0] tblVal  [RULES] = '{5'b00000, 5'b00100, 5'b00000, 5'b10000,
                                        5'b01000, 5'b00100, 5'b00010, 5'b00000};

  // A rule hits when enabled and every literal it cares about agrees with the input bit.
  function automatic logic [RULES-1:0] refMatch(input logic [WIDTH-1:0] d);
    logic [RULES-1:0] m;
    bit ok;
    m = '0;
    for (int r = 0; r < RULES; r++) begin
      ok = mEn[r];
      for (int b = 0; b < WIDTH; b++) begin
        if (mMask[r][b] && (d[b] != mVal[r][b])) ok = 1'b0;
      end
      m[r] = ok;
    end
    return m;
  endfunction

  function automatic int refFirst(input logic [RULES-1:0] m);
    for (int r = 0; r < RULES; r++) begin
      if (m[r]) return r;
    end
    return 0;
  endfunction

  task automatic resetModel();
    expQ.delete();
    for (int r = 0; r < RULES; r++) begin
      mEn[r]   = 1'b0;
      mMask[r] = '0;
      mVal[r]  = '0;
      mCnt[r]  = 0;
    end
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    assert (observed === expected) passCount++;
    else begin
      failCount++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Checks the settled outputs against the model, then advances model and DUT one clock.
  task automatic stepCycle();
    logic             expValid;
    logic             expReady;
    logic [RULES-1:0] expMatch;
    beat_t            b;
    int               idx;
    idx      = $urandom_range(0, RULES - 1);
    cnt_idx  = IDX_W'(idx);
    #1;
    expValid = (expQ.size() > 0) && expQ[0].resolved;
    expReady = !rst_n || !expValid || out_ready;
    expMatch = '0;
    checkOutput("out_valid", out_valid, expValid);
    checkOutput("in_ready", in_ready, expReady);
    checkOutput("cnt_value", cnt_value, mCnt[idx]);
    if (expValid) begin
      expMatch = expQ[0].match;
      checkOutput("out_match", out_match, expMatch);
      checkOutput("out_any", out_any, expMatch != '0);
      checkOutput("out_first", out_first, refFirst(expMatch));
    end
    if (!rst_n) begin
      resetModel();
    end else begin
      if (expValid && out_ready) begin
        for (int r = 0; r < RULES; r++) begin
          if (expMatch[r] && (mCnt[r] < CNT_MAX)) mCnt[r]++;
        end
        void'(expQ.pop_front());
      end
      if (expReady) begin
        for (int i = 0; i < expQ.size(); i++) begin
          if (!expQ[i].resolved) begin
            b          = expQ[i];
            b.resolved = 1'b1;
            b.match    = refMatch(b.data);
            expQ[i]    = b;
            break;
          end
        end
      end
      if (in_valid && expReady) begin
        b.data     = in_data;
        b.resolved = 1'b0;
        b.match    = '0;
        expQ.push_back(b);
      end
      if (cnt_clr) begin
        for (int r = 0; r < RULES; r++) mCnt[r] = 0;
      end
      if (cfg_we) begin
        mEn[cfg_idx]   = cfg_en;
        mMask[cfg_idx] = cfg_mask;
        mVal[cfg_idx]  = cfg_val;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic v, input logic [WIDTH-1:0] d, input logic rdy);
    in_valid  = v;
    in_data   = d;
    out_ready = rdy;
    stepCycle();
  endtask

  task automatic writeRule(input int idx, input logic en, input logic [WIDTH-1:0] mask, input logic [WIDTH-1:0] val);
    cfg_we   = 1'b1;
    cfg_idx  = IDX_W'(idx);
    cfg_en   = en;
    cfg_mask = mask;
    cfg_val  = val;
    stepCycle();
    cfg_we   = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; cfg_we = 1'b0; cfg_idx = '0; cfg_en = 1'b0; cfg_mask = '0; cfg_val = '0;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b0; cnt_idx = '0; cnt_clr = 1'b0;
    @(posedge clk);
    #1;
    resetModel();

    // Reset with traffic offered and downstream not ready.
    applyStimulus(1'b1, 5'b10101, 1'b0);
    applyStimulus(1'b1, 5'b01010, 1'b0);
    checkOutput("reset out_match", out_match, 8'h00);
    checkOutput("reset out_any", out_any, 1'b0);
    checkOutput("reset out_first", out_first, 3'd0);
    rst_n = 1'b1;

    // Empty table matches nothing.
    applyStimulus(1'b1, 5'b00000, 1'b1);
    applyStimulus(1'b0, 5'b00000, 1'b1);
    checkOutput("empty table out_valid", out_valid, 1'b1);
    checkOutput("empty table out_match", out_match, 8'h00);

    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int r = 0; r < RULES; r++) writeRule(r, 1'b1, tblMask[r], tblVal[r]);

    applyStimulus(1'b1, 5'b00100, 1'b1);
    checkOutput("latency one cycle out_valid", out_valid, 1'b0);
    applyStimulus(1'b0, 5'b00000, 1'b1);
    checkOutput("default table 00100 out_valid", out_valid, 1'b1);
    checkOutput("default table 00100 out_match", out_match, 8'hA7);
    checkOutput("default table 00100 out_any", out_any, 1'b1);
    checkOutput("default table 00100 out_first", out_first, 3'd0);

    applyStimulus(1'b1, 5'b11111, 1'b1);
    applyStimulus(1'b0, 5'b00000, 1'b1);
    checkOutput("default table 11111 out_match", out_match, 8'h60);
    checkOutput("default table 11111 out_first", out_first, 3'd5);
    writeRule(5, 1'b0, 5'b00100, 5'b00100);
    applyStimulus(1'b1, 5'b11111, 1'b1);
    applyStimulus(1'b0, 5'b00000, 1'b1);
    checkOutput("r5 disabled out_match", out_match, 8'h40);
    checkOutput("r5 disabled out_first", out_first, 3'd6);

    // A write landing on the same edge the beat leaves S1 is not yet seen by it.
    applyStimulus(1'b1, 5'b11111, 1'b1);
    in_valid = 1'b0;
    writeRule(5, 1'b1, 5'b00100, 5'b00100);
    checkOutput("same-edge cfg out_match", out_match, 8'h40);
    in_valid = 1'b1;
    in_data  = 5'b11111;
    writeRule(6, 1'b0, 5'b00010, 5'b00010);
    applyStimulus(1'b0, 5'b00000, 1'b1);
    checkOutput("prior-edge cfg out_match", out_match, 8'h20);
    checkOutput("prior-edge cfg out_first", out_first, 3'd5);
    in_valid = 1'b0;
    writeRule(6, 1'b1, 5'b00010, 5'b00010);

    // Back-pressure: four beats with a three-cycle stall after the first result.
    applyStimulus(1'b1, 5'b00100, 1'b1);
    applyStimulus(1'b1, 5'b11111, 1'b1);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 5'b00000, 1'b0);
      checkOutput("stall holds first result", out_match, 8'hA7);
    end
    applyStimulus(1'b1, 5'b00000, 1'b1);
    applyStimulus(1'b1, 5'b10001, 1'b1);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 5'b00000, 1'b1);
    checkOutput("stall stream drained", out_valid, 1'b0);

    for (int n = 0; n < 250; n++) begin
      cfg_we   = ($urandom_range(0, 9) == 0);
      cfg_idx  = IDX_W'($urandom_range(0, RULES - 1));
      cfg_en   = ($urandom_range(0, 3) != 0);
      cfg_mask = WIDTH'($urandom) & WIDTH'($urandom);
      cfg_val  = WIDTH'($urandom);
      cnt_clr  = ($urandom_range(0, 29) == 0);
      in_valid = ($urandom_range(0, 9) < 7);
      in_data  = WIDTH'($urandom);
      out_ready = ($urandom_range(0, 9) < 7);
      stepCycle();
    end
    cfg_we  = 1'b0;
    cnt_clr = 1'b0;

    // Hit-counter saturation and clear priority on rule 5.
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 5'b00000, 1'b1);
    writeRule(5, 1'b1, 5'b00100, 5'b00100);
    cnt_clr = 1'b1;
    applyStimulus(1'b0, 5'b00000, 1'b1);
    cnt_clr = 1'b0;
    for (int i = 0; i < 20; i++) applyStimulus(1'b1, WIDTH'($urandom) | 5'b00100, 1'b1);
    applyStimulus(1'b0, 5'b00000, 1'b1);
    applyStimulus(1'b0, 5'b00000, 1'b1);
    cnt_idx = 3'd5;
    #1;
    checkOutput("r5 counter saturated", cnt_value, 4'd15);
    applyStimulus(1'b1, 5'b00100, 1'b1);
    applyStimulus(1'b0, 5'b00000, 1'b1);
    cnt_clr = 1'b1;
    applyStimulus(1'b0, 5'b00000, 1'b1);
    cnt_clr = 1'b0;
    cnt_idx = 3'd5;
    #1;
    checkOutput("clear beats increment", cnt_value, 4'd0);

    // Reset with two beats in flight.
    applyStimulus(1'b1, 5'b00100, 1'b1);
    applyStimulus(1'b1, 5'b11111, 1'b1);
    rst_n = 1'b0;
    applyStimulus(1'b1, 5'b00000, 1'b0);
    checkOutput("mid-stream reset out_valid", out_valid, 1'b0);
    rst_n = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int r = 0; r < RULES; r++) begin
      cnt_idx = IDX_W'(r);
      #1;
      checkOutput("counter cleared by reset", cnt_value, 4'd0);
    end
    @(posedge clk);
    #1;
    applyStimulus(1'b1, 5'b00100, 1'b1);
    applyStimulus(1'b1, 5'b11111, 1'b1);
    checkOutput("table cleared out_valid", out_valid, 1'b1);
    checkOutput("table cleared out_match", out_match, 8'h00);
    checkOutput("table cleared out_first", out_first, 3'd0);
    applyStimulus(1'b0, 5'b00000, 1'b1);
    checkOutput("table cleared second beat", out_match, 8'h00);
    applyStimulus(1'b0, 5'b00000, 1'b1);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
